conv_tile_seq: RTL and testbench

- Parametrised successor to the 5x5 PE control sequencer for the CNN accelerator.
- Drives IFM and weight buffer reads, plus partial-sum valid and last-channel flags, for a KSIZE x KSIZE convolution over one tile row per input channel.
- Iterates input channels, then output rows, then output channel groups.
- Adds: runtime row count, stall back-pressure, a real FINISH/done pulse, and a parametrised PE pipeline delay.

---
 rtl/conv_seq_pkg.sv | 21 ++
 rtl/conv_seq_dly.sv | 29 ++
 rtl/conv_tile_seq.sv | 187 ++++++++++++++++++
 tb/tb_conv_tile_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and sizing helpers for the conv tile sequencer
package conv_seq_pkg;

   // Sequencer phases: FILL primes the kernel window, STREAM emits one tile row
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      FINISH = 2'd3
   } seq_state_e;

   localparam int CH_GRP_DEF = 8;

   // Bits needed for a channel index up to (2**cfg_w)*ch_grp-1
   function automatic int ch_cnt_w(input int cfg_w, input int ch_grp);
      int n;
      n = (1 << cfg_w) * ch_grp;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_seq_dly.sv
// rtl/conv_seq_dly.sv - WIDTH x DEPTH shift chain matching the PE datapath latency
module conv_seq_dly #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift every cycle; clr flushes the whole chain at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_tile_seq.sv
// rtl/conv_tile_seq.sv - KSIZE x KSIZE conv tile sequencer; optional abort via CONV_TILE_SEQ_ABORT_EN
module conv_tile_seq
   import conv_seq_pkg::*;
#(
   parameter int TILE_LEN = 16,
   parameter int KSIZE    = 5,
   parameter int CH_GRP   = CH_GRP_DEF,
   parameter int CFG_W    = 2,
   parameter int ROW_W    = 6,
   parameter int PIPE_DLY = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CFG_W-1:0] cfg_ci,
   input  logic [CFG_W-1:0] cfg_co,
   input  logic [ROW_W-1:0] cfg_rows,
   input  logic             stall,
`ifdef CONV_TILE_SEQ_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             ifm_read,
   output logic             wgt_read,
   output logic             p_valid_out,
   output logic             last_ch_out,
   output logic             busy,
   output logic             done
);

   localparam int CW   = ch_cnt_w(CFG_W, CH_GRP);
   localparam int PMAX = (KSIZE - 1 > TILE_LEN) ? KSIZE - 1 : TILE_LEN;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [PW-1:0] FILL_LAST   = PW'(KSIZE - 2);
   localparam logic [PW-1:0] STREAM_LAST = PW'(TILE_LEN - 1);

   seq_state_e       state_q, state_d;
   logic [PW-1:0]    pix_q, pix_d;
   logic [CW-1:0]    ci_q, ci_d;
   logic [CW-1:0]    co_q, co_d;
   logic [ROW_W-1:0] row_q, row_d;
   // Last-index values are stored so max cfg never needs an extra bit
   logic [CW-1:0]    ci_last_q, ci_last_d;
   logic [CW-1:0]    co_last_q, co_last_d;
   logic [ROW_W-1:0] row_last_q, row_last_d;

   logic             active;
   logic             abort_hit;
   logic             p_valid_int;
   logic             last_ch_int;
   logic [1:0]       dly_out;

`ifdef CONV_TILE_SEQ_ABORT_EN
   assign abort_hit = abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // State and loop-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         ci_q       <= '0;
         co_q       <= '0;
         row_q      <= '0;
         ci_last_q  <= '0;
         co_last_q  <= '0;
         row_last_q <= '0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         ci_q       <= ci_d;
         co_q       <= co_d;
         row_q      <= row_d;
         ci_last_q  <= ci_last_d;
         co_last_q  <= co_last_d;
         row_last_q <= row_last_d;
      end
   end

   // Next state: pixel innermost, then input channel, row, output channel group
   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      ci_d       = ci_q;
      co_d       = co_q;
      row_d      = row_q;
      ci_last_d  = ci_last_q;
      co_last_d  = co_last_q;
      row_last_d = row_last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = FILL;
               pix_d      = '0;
               ci_d       = '0;
               co_d       = '0;
               row_d      = '0;
               ci_last_d  = CW'((int'(cfg_ci) + 1) * CH_GRP - 1);
               co_last_d  = CW'((int'(cfg_co) + 1) * CH_GRP - 1);
               row_last_d = cfg_rows;
            end
         end
         FILL: begin
            if (!stall) begin
               if (pix_q == FILL_LAST) begin
                  pix_d   = '0;
                  state_d = STREAM;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
         STREAM: begin
            if (!stall) begin
               if (pix_q == STREAM_LAST) begin
                  pix_d   = '0;
                  state_d = FILL;
                  if (ci_q == ci_last_q) begin
                     ci_d = '0;
                     if (row_q == row_last_q) begin
                        row_d = '0;
                        if (co_q == co_last_q) begin
                           co_d    = '0;
                           state_d = FINISH;
                        end else begin
                           co_d = co_q + 1'b1;
                        end
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     ci_d = ci_q + 1'b1;
                  end
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) begin
         state_d = IDLE;
         pix_d   = '0;
         ci_d    = '0;
         co_d    = '0;
         row_d   = '0;
      end
   end

   assign active      = (state_q == FILL) || (state_q == STREAM);
   assign ifm_read    = active && !stall;
   assign wgt_read    = active && !stall;
   assign busy        = active;
   assign done        = (state_q == FINISH) && !abort_hit;
   assign p_valid_int = (state_q == STREAM) && !stall && !abort_hit;
   assign last_ch_int = p_valid_int && (ci_q == ci_last_q);

`ifdef CONV_TILE_SEQ_ABORT_EN
   logic aborted_q;

   // One-cycle acknowledgement in the cycle after an accepted abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) aborted_q <= 1'b0;
      else        aborted_q <= abort_hit;
   end

   assign aborted = aborted_q;
`endif

   conv_seq_dly #(
      .WIDTH (2),
      .DEPTH (PIPE_DLY)
   ) u_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (abort_hit),
      .din_i  ({p_valid_int, last_ch_int}),
      .dout_o (dly_out)
   );

   assign p_valid_out = dly_out[1];
   assign last_ch_out = dly_out[0];

endmodule

// File: tb/tb_conv_tile_seq.sv
// tb/tb_conv_tile_seq.sv - directed self-checking bench for conv_tile_seq
module tb_conv_tile_seq;

   localparam int TILE_LEN = 4;
   localparam int KSIZE    = 3;
   localparam int CH_GRP   = 8;
   localparam int CFG_W    = 2;
   localparam int ROW_W    = 6;
   localparam int PIPE_DLY = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CFG_W-1:0] cfg_ci;
   logic [CFG_W-1:0] cfg_co;
   logic [ROW_W-1:0] cfg_rows;
   logic             stall;
   logic             ifm_read;
   logic             wgt_read;
   logic             p_valid_out;
   logic             last_ch_out;
   logic             busy;
   logic             done;
`ifdef CONV_TILE_SEQ_ABORT_EN
   logic             abort;
   logic             aborted;
`endif

   always #5 clk = ~clk;

   conv_tile_seq #(
      .TILE_LEN (TILE_LEN),
      .KSIZE    (KSIZE),
      .CH_GRP   (CH_GRP),
      .CFG_W    (CFG_W),
      .ROW_W    (ROW_W),
      .PIPE_DLY (PIPE_DLY)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_ci      (cfg_ci),
      .cfg_co      (cfg_co),
      .cfg_rows    (cfg_rows),
      .stall       (stall),
`ifdef CONV_TILE_SEQ_ABORT_EN
      .abort       (abort),
      .aborted     (aborted),
`endif
      .ifm_read    (ifm_read),
      .wgt_read    (wgt_read),
      .p_valid_out (p_valid_out),
      .last_ch_out (last_ch_out),
      .busy        (busy),
      .done        (done)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   int cyc          = 0;
   int rd_cnt       = 0;
   int pv_cnt       = 0;
   int rd_stall_cnt = 0;
   int rw_mis       = 0;
   int lc_bad       = 0;
   int last_rd_cyc  = 0;
   int last_pv_cyc  = 0;
   int lc_q[$];
   int pv_q[$];
   int done_q[$];
   logic [7:0] rd_hist = '0;

   // Observation monitor on the falling edge
   always @(negedge clk) begin
      cyc     <= cyc + 1;
      rd_hist <= {rd_hist[6:0], ifm_read};
      if (ifm_read) begin
         rd_cnt      <= rd_cnt + 1;
         last_rd_cyc <= cyc + 1;
         if (stall) rd_stall_cnt <= rd_stall_cnt + 1;
      end
      if (ifm_read !== wgt_read) rw_mis <= rw_mis + 1;
      if (p_valid_out) begin
         pv_cnt      <= pv_cnt + 1;
         last_pv_cyc <= cyc + 1;
         pv_q.push_back(cyc + 1);
      end
      if (last_ch_out) begin
         lc_q.push_back(cyc + 1);
         if (!rd_hist[PIPE_DLY-1] || !p_valid_out) lc_bad <= lc_bad + 1;
      end
      if (done) done_q.push_back(cyc + 1);
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, observed time %0t required < 400000", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns the monitor cycle number at which the first read is expected
   task automatic pulse_start(input int ci, input int co, input int rows, output int base);
      cfg_ci   = CFG_W'(ci);
      cfg_co   = CFG_W'(co);
      cfg_rows = ROW_W'(rows);
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
      base     = cyc + 1;
   endtask

   task automatic wait_done(input int n0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (done_q.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   int base, rd0, pv0, lcn, pvn, dn, rs0, rdr;
   bit ok;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      stall    = 1'b0;
      cfg_ci   = '0;
      cfg_co   = '0;
      cfg_rows = '0;
`ifdef CONV_TILE_SEQ_ABORT_EN
      abort    = 1'b0;
`endif
      tick(3);
      check("rst_busy", busy, 0);
      check("rst_ifm_read", ifm_read, 0);
      check("rst_p_valid", p_valid_out, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      tick(2);

      // Job 1: minimal config, 8 ci x 1 row x 8 co
      rd0 = rd_cnt; pv0 = pv_cnt; lcn = lc_q.size(); pvn = pv_q.size(); dn = done_q.size();
      pulse_start(0, 0, 0, base);
      #3;
      check("j1_first_ifm_read", ifm_read, 1);
      check("j1_first_wgt_read", wgt_read, 1);
      check("j1_busy", busy, 1);
      check("j1_pv_early", p_valid_out, 0);
      wait_done(dn, 600, ok);
      check("j1_done_seen", ok, 1);
      check("j1_done_cyc", (done_q.size() > dn) ? done_q[dn] : -1, base + 384);
      check("j1_last_rd_cyc", last_rd_cyc, base + 383);
      check("j1_busy_after", busy, 0);
      tick(8);
      check("j1_reads", rd_cnt - rd0, 384);
      check("j1_pv_cnt", pv_cnt - pv0, 256);
      check("j1_lc_cnt", lc_q.size() - lcn, 32);
      check("j1_first_lc_cyc", (lc_q.size() > lcn) ? lc_q[lcn] : -1, base + 48);
      check("j1_first_pv_cyc", (pv_q.size() > pvn) ? pv_q[pvn] : -1, base + 2 + PIPE_DLY);
      check("j1_last_pv_cyc", last_pv_cyc, base + 383 + PIPE_DLY);
      check("j1_done_count", done_q.size() - dn, 1);
      check("j1_lc_alignment", lc_bad, 0);
      check("j1_rd_wgt_match", rw_mis, 0);

      // Job 2: 16 ci x 3 rows x 8 co
      rd0 = rd_cnt; pv0 = pv_cnt; lcn = lc_q.size(); dn = done_q.size();
      pulse_start(1, 0, 2, base);
      wait_done(dn, 2600, ok);
      check("j2_done_seen", ok, 1);
      check("j2_done_cyc", (done_q.size() > dn) ? done_q[dn] : -1, base + 2304);
      tick(8);
      check("j2_reads", rd_cnt - rd0, 2304);
      check("j2_pv_cnt", pv_cnt - pv0, 1536);
      check("j2_lc_cnt", lc_q.size() - lcn, 96);
      check("j2_done_count", done_q.size() - dn, 1);
      check("j2_busy_after", busy, 0);

      // Job 3: stall for 10 cycles starting in the first STREAM phase
      rd0 = rd_cnt; pv0 = pv_cnt; dn = done_q.size(); rs0 = rd_stall_cnt;
      pulse_start(0, 0, 0, base);
      tick(3);
      stall = 1'b1;
      #3;
      check("j3_read_in_stall", ifm_read, 0);
      check("j3_busy_in_stall", busy, 1);
      tick(10);
      stall = 1'b0;
      wait_done(dn, 600, ok);
      check("j3_done_seen", ok, 1);
      check("j3_done_cyc", (done_q.size() > dn) ? done_q[dn] : -1, base + 384 + 10);
      tick(8);
      check("j3_reads", rd_cnt - rd0, 384);
      check("j3_stall_reads", rd_stall_cnt - rs0, 0);
      check("j3_pv_cnt", pv_cnt - pv0, 256);

      // Job 4: start re-pulsed mid-job with a different cfg is ignored
      rd0 = rd_cnt; dn = done_q.size();
      pulse_start(0, 0, 0, base);
      tick(20);
      cfg_ci = 2'd3;
      start  = 1'b1;
      tick(1);
      start  = 1'b0;
      wait_done(dn, 600, ok);
      check("j4_done_seen", ok, 1);
      check("j4_done_cyc", (done_q.size() > dn) ? done_q[dn] : -1, base + 384);
      tick(8);
      check("j4_reads", rd_cnt - rd0, 384);
      cfg_ci = '0;

      // Job 5: asynchronous reset mid-job
      dn = done_q.size();
      pulse_start(0, 0, 0, base);
      tick(20);
      #2;
      rst_n = 1'b0;
      #1;
      check("j5_rst_busy", busy, 0);
      check("j5_rst_ifm_read", ifm_read, 0);
      check("j5_rst_wgt_read", wgt_read, 0);
      check("j5_rst_p_valid", p_valid_out, 0);
      check("j5_rst_last_ch", last_ch_out, 0);
      check("j5_rst_done", done, 0);
      tick(2);
      rst_n = 1'b1;
      rdr = rd_cnt;
      tick(20);
      check("j5_no_done", done_q.size() - dn, 0);
      check("j5_no_reads", rd_cnt - rdr, 0);
      check("j5_busy_after", busy, 0);

`ifdef CONV_TILE_SEQ_ABORT_EN
      // Job 6: abort on the 50th read cycle
      dn = done_q.size();
      pulse_start(0, 0, 0, base);
      tick(49);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      #2;
      check("j6_abort_busy", busy, 0);
      check("j6_aborted", aborted, 1);
      check("j6_abort_read", ifm_read, 0);
      check("j6_abort_pv", p_valid_out, 0);
      pv0 = pv_cnt;
      tick(1);
      check("j6_aborted_pulse", aborted, 0);
      tick(10);
      check("j6_pv_after", pv_cnt - pv0, 0);
      check("j6_no_done", done_q.size() - dn, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
